// File: rtl/rvfi_commit_buffer.sv
// rvfi_commit_buffer
// In-order commit buffer between the MEM/WB capture point and the RVFI monitor.
// Each valid, unstalled, unflushed cycle captures one retirement packet into a
// DEPTH-entry circular queue. The head packet is presented as a ready/valid
// commit stream with a 64-bit retirement order. On output, rd_wdata is forced to
// zero for rd==x0; the stored entry itself is left unchanged.
//
// Optional feature: define RVFI_HALT_DETECT_EN to build the sticky halt detector.
// A halt is detected when the committing packet has pc_wdata == pc_rdata. If the
// macro is undefined, halt is tied to 0.
//
// Ports:
//   clk        clock; all state changes on posedge
//   rst        asynchronous reset, active-low (0 = reset)
//   cap_valid  capture stage holds a real instruction
//   cap_stall  capture is suppressed while high; the queue still drains
//   cap_flush  discards all queued packets and any same-cycle capture
//   cap_pkt    packet, MSB first: {inst,pc_rdata,pc_wdata,rs1_rdata,rs2_rdata,
//              rd_wdata,mem_addr,mem_rdata,mem_wdata,rs1_addr,rs2_addr,rd_addr,
//              mem_rmask,mem_wmask,load_regfile,trap}
//   out_ready  monitor accepts the head packet
//   out_valid  head packet available
//   out_pkt    head packet, same layout, with rd==x0 scrubbing applied
//   commit     out_valid & out_ready
//   order      order of the head packet; counts commits from 0
//   count      number of queued packets, 0..DEPTH
//   overflow   sticky: a capture arrived while full and nothing popped
//   halt       sticky halt flag (RVFI_HALT_DETECT_EN only)
module rvfi_commit_buffer #(
  parameter  int XLEN  = 32,
  parameter  int DEPTH = 4,
  localparam int PKT_W = 9*XLEN + 15 + XLEN/4 + 2,
  localparam int CNT_W = $clog2(DEPTH) + 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             cap_valid,
  input  logic             cap_stall,
  input  logic             cap_flush,
  input  logic [PKT_W-1:0] cap_pkt,
  input  logic             out_ready,
  output logic             out_valid,
  output logic [PKT_W-1:0] out_pkt,
  output logic             commit,
  output logic [63:0]      order,
  output logic [CNT_W-1:0] count,
  output logic             overflow,
  output logic             halt
);

  localparam int PTR_W        = $clog2(DEPTH);
  localparam int MASK_W       = XLEN/8;
  // Field offsets counted from the LSB end of the packet.
  localparam int RD_ADDR_LSB  = 2 + 2*MASK_W;
  localparam int DATA_LSB     = RD_ADDR_LSB + 15;
  localparam int RD_WDATA_LSB = DATA_LSB + 3*XLEN;

  logic [PKT_W-1:0] mem [DEPTH];
  logic [PTR_W-1:0] wr_ptr;
  logic [PTR_W-1:0] rd_ptr;
  logic             push;
  logic             pop;
  logic             store;
  logic             full;
  logic             empty;

  function automatic logic [PKT_W-1:0] scrub_rd(input logic [PKT_W-1:0] pkt);
    logic [PKT_W-1:0] res;
    res = pkt;
    if (pkt[RD_ADDR_LSB +: 5] == 5'd0) res[RD_WDATA_LSB +: XLEN] = '0;
    return res;
  endfunction

  assign full      = (count == CNT_W'(DEPTH));
  assign empty     = (count == '0);
  assign push      = cap_valid & ~cap_stall & ~cap_flush;
  assign out_valid = ~empty;
  assign pop       = out_valid & out_ready;
  assign commit    = pop;
  // When full, a capture only fits if the head leaves in the same cycle.
  assign store     = push & (~full | pop);
  assign out_pkt   = scrub_rd(mem[rd_ptr]);

  // Queue control and commit bookkeeping
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      wr_ptr   <= '0;
      rd_ptr   <= '0;
      count    <= '0;
      order    <= '0;
      overflow <= 1'b0;
    end else begin
      if (pop) order <= order + 64'd1;
      if (push & full & ~pop) overflow <= 1'b1;
      if (cap_flush) begin
        wr_ptr <= '0;
        rd_ptr <= '0;
        count  <= '0;
      end else begin
        if (store) wr_ptr <= wr_ptr + PTR_W'(1);
        if (pop)   rd_ptr <= rd_ptr + PTR_W'(1);
        case ({store, pop})
          2'b10:   count <= count + CNT_W'(1);
          2'b01:   count <= count - CNT_W'(1);
          default: count <= count;
        endcase
      end
    end
  end

  // Packet storage (data only, no reset)
  always_ff @(posedge clk) begin
    if (store) mem[wr_ptr] <= cap_pkt;
  end

`ifdef RVFI_HALT_DETECT_EN
  localparam int PC_WDATA_LSB = DATA_LSB + 6*XLEN;
  localparam int PC_RDATA_LSB = DATA_LSB + 7*XLEN;

  logic halt_hit;

  // A committing instruction that jumps to itself marks the end of the program.
  assign halt_hit = pop &
                    (mem[rd_ptr][PC_WDATA_LSB +: XLEN] == mem[rd_ptr][PC_RDATA_LSB +: XLEN]);

  always_ff @(posedge clk or negedge rst) begin
    if (!rst)          halt <= 1'b0;
    else if (halt_hit) halt <= 1'b1;
  end
`else
  assign halt = 1'b0;
`endif

endmodule

// File: tb/tb_rvfi_commit_buffer.sv
// Self-checking bench for rvfi_commit_buffer (XLEN=32, DEPTH=4): a vector table,
// directed multi-cycle sequences and a randomized run against a queue model.
module tb_rvfi_commit_buffer;

  localparam int XLEN  = 32;
  localparam int DEPTH = 4;
  localparam int PKT_W = 9*XLEN + 15 + XLEN/4 + 2;
  localparam int CNT_W = $clog2(DEPTH) + 1;

  typedef struct packed {
    logic [31:0] inst, pc_rdata, pc_wdata, rs1_rdata, rs2_rdata, rd_wdata,
                 mem_addr, mem_rdata, mem_wdata;
    logic [4:0]  rs1_addr, rs2_addr, rd_addr;
    logic [3:0]  mem_rmask, mem_wmask;
    logic        load_regfile, trap;
  } rvfi_pkt_t;

  typedef struct {
    logic        v, s, f, r;
    logic [31:0] pc;
    logic [4:0]  rd;
    logic [31:0] wd;
    logic        e_valid, e_commit;
    int          e_count;
    logic [63:0] e_order;
    logic [31:0] e_pc, e_wd;
  } vec_t;

  logic             clk = 1'b0;
  logic             rst;
  logic             cap_valid, cap_stall, cap_flush, out_ready;
  logic [PKT_W-1:0] cap_pkt;
  logic             out_valid, commit, overflow, halt;
  logic [PKT_W-1:0] out_pkt;
  logic [63:0]      order;
  logic [CNT_W-1:0] count;
  rvfi_pkt_t        head;

  int passed = 0;
  int total  = 0;

  assign head = out_pkt;

  always #5 clk = ~clk;

  rvfi_commit_buffer #(.XLEN(XLEN), .DEPTH(DEPTH)) dut (
    .clk(clk), .rst(rst), .cap_valid(cap_valid), .cap_stall(cap_stall),
    .cap_flush(cap_flush), .cap_pkt(cap_pkt), .out_ready(out_ready),
    .out_valid(out_valid), .out_pkt(out_pkt), .commit(commit), .order(order),
    .count(count), .overflow(overflow), .halt(halt)
  );

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    else passed++;
  endtask

  task automatic chk_pkt(input string name, input rvfi_pkt_t act, input rvfi_pkt_t exp);
    total++;
    if (act !== exp) $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    else passed++;
  endtask

  function automatic rvfi_pkt_t mk_pkt(input logic [31:0] pc, input logic [31:0] pcw,
                                       input logic [4:0] rd, input logic [31:0] wd);
    rvfi_pkt_t p;
    p.inst         = {20'h0, rd, 7'h13};
    p.pc_rdata     = pc;
    p.pc_wdata     = pcw;
    p.rs1_rdata    = pc ^ 32'h1111_1111;
    p.rs2_rdata    = pc ^ 32'h2222_2222;
    p.rd_wdata     = wd;
    p.mem_addr     = pc + 32'h1000;
    p.mem_rdata    = 32'hA5A5_0000 | pc;
    p.mem_wdata    = 32'h5A5A_0000 | pc;
    p.rs1_addr     = 5'd1;
    p.rs2_addr     = 5'd2;
    p.rd_addr      = rd;
    p.mem_rmask    = 4'hF;
    p.mem_wmask    = 4'h3;
    p.load_regfile = (rd != 5'd0);
    p.trap         = 1'b0;
    return p;
  endfunction

  function automatic rvfi_pkt_t scrubbed(input rvfi_pkt_t p);
    rvfi_pkt_t q;
    q = p;
    if (p.rd_addr == 5'd0) q.rd_wdata = 32'h0;
    return q;
  endfunction

  function automatic rvfi_pkt_t rand_pkt();
    rvfi_pkt_t p;
    p = {$urandom, $urandom, $urandom, $urandom, $urandom, $urandom, $urandom,
         $urandom, $urandom, 25'($urandom)};
    if ($urandom_range(0, 3) == 0) p.rd_addr = 5'd0;
    if ($urandom_range(0, 7) == 0) p.pc_wdata = p.pc_rdata;
    return p;
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic set_in(input logic v, input logic s, input logic f, input logic r,
                        input rvfi_pkt_t p);
    cap_valid = v;
    cap_stall = s;
    cap_flush = f;
    out_ready = r;
    cap_pkt   = p;
  endtask

  task automatic do_reset();
    set_in(1'b0, 1'b0, 1'b0, 1'b0, '0);
    rst = 1'b0;
    tick();
    tick();
    rst = 1'b1;
  endtask

  task automatic push_n(input int n, input logic [31:0] base);
    for (int k = 0; k < n; k++) begin
      set_in(1'b1, 1'b0, 1'b0, 1'b0, mk_pkt(base + 32'(4*k), base + 32'(4*k) + 32'd4, 5'd1, 32'(k)));
      tick();
    end
    set_in(1'b0, 1'b0, 1'b0, 1'b0, '0);
  endtask

  vec_t        tbl [9];
  rvfi_pkt_t   mq [$];
  logic [63:0] m_order;
  logic        m_ovf, m_halt, m_pop, m_push, m_full;
  rvfi_pkt_t   rp;

  initial begin
    tbl[0] = '{1,0,0,1, 32'h60, 5'd5, 32'hAB,    0,0,0, 64'd0, 32'h0,   32'h0};
    tbl[1] = '{0,0,0,1, 32'h0,  5'd0, 32'h0,     1,1,1, 64'd0, 32'h60,  32'hAB};
    tbl[2] = '{0,0,0,0, 32'h0,  5'd0, 32'h0,     0,0,0, 64'd1, 32'h0,   32'h0};
    tbl[3] = '{1,0,0,0, 32'h100,5'd0, 32'hDEAD,  0,0,0, 64'd1, 32'h0,   32'h0};
    tbl[4] = '{1,1,0,0, 32'h200,5'd7, 32'h77,    1,0,1, 64'd1, 32'h100, 32'h0};
    tbl[5] = '{0,0,0,0, 32'h0,  5'd0, 32'h0,     1,0,1, 64'd1, 32'h100, 32'h0};
    tbl[6] = '{1,0,0,1, 32'h104,5'd3, 32'h55,    1,1,1, 64'd1, 32'h100, 32'h0};
    tbl[7] = '{0,0,0,1, 32'h0,  5'd0, 32'h0,     1,1,1, 64'd2, 32'h104, 32'h55};
    tbl[8] = '{0,0,0,0, 32'h0,  5'd0, 32'h0,     0,0,0, 64'd3, 32'h0,   32'h0};

    // Reset state
    do_reset();
    #1;
    chk("rst_out_valid", 64'(out_valid), 64'd0);
    chk("rst_count",     64'(count),     64'd0);
    chk("rst_order",     order,          64'd0);
    chk("rst_overflow",  64'(overflow),  64'd0);
    chk("rst_halt",      64'(halt),      64'd0);

    // Vector table: single packet, scrubbing, stall, push+pop
    for (int i = 0; i < 9; i++) begin
      set_in(tbl[i].v, tbl[i].s, tbl[i].f, tbl[i].r,
             mk_pkt(tbl[i].pc, tbl[i].pc + 32'd4, tbl[i].rd, tbl[i].wd));
      #1;
      chk($sformatf("tbl%0d_valid", i),  64'(out_valid), 64'(tbl[i].e_valid));
      chk($sformatf("tbl%0d_commit", i), 64'(commit),    64'(tbl[i].e_commit));
      chk($sformatf("tbl%0d_count", i),  64'(count),     64'(tbl[i].e_count));
      chk($sformatf("tbl%0d_order", i),  order,          tbl[i].e_order);
      if (tbl[i].e_valid) begin
        chk($sformatf("tbl%0d_pc", i), 64'(head.pc_rdata), 64'(tbl[i].e_pc));
        chk($sformatf("tbl%0d_wd", i), 64'(head.rd_wdata), 64'(tbl[i].e_wd));
      end
      tick();
    end

    // Fill past full with no pop: fifth packet dropped, overflow sticks
    do_reset();
    push_n(5, 32'h0);
    #1;
    chk("fill_count",    64'(count),    64'd4);
    chk("fill_overflow", 64'(overflow), 64'd1);
    tick();
    for (int k = 0; k < 4; k++) begin
      out_ready = 1'b1;
      #1;
      chk($sformatf("fill_commit%0d", k), 64'(commit),        64'd1);
      chk($sformatf("fill_pc%0d", k),     64'(head.pc_rdata), 64'(4*k));
      chk($sformatf("fill_order%0d", k),  order,              64'(k));
      tick();
    end
    out_ready = 1'b0;
    #1;
    chk("fill_drained", 64'(out_valid), 64'd0);
    chk("fill_order4",  order,          64'd4);
    chk("fill_ovf_sticky", 64'(overflow), 64'd1);

    // Asynchronous reset mid-run with three packets queued
    tick();
    push_n(3, 32'h40);
    #1;
    chk("arst_pre_count", 64'(count), 64'd3);
    #1;
    rst = 1'b0;
    #1;
    chk("arst_valid",    64'(out_valid), 64'd0);
    chk("arst_count",    64'(count),     64'd0);
    chk("arst_order",    order,          64'd0);
    chk("arst_overflow", 64'(overflow),  64'd0);
    tick();
    rst = 1'b1;

    // Full + push + pop in the same cycle, with pointers offset to force a wrap
    do_reset();
    push_n(2, 32'h10);
    out_ready = 1'b1;
    tick();
    tick();
    out_ready = 1'b0;
    push_n(4, 32'h20);
    #1;
    chk("wrap_full", 64'(count), 64'd4);
    for (int k = 0; k < 2; k++) begin
      set_in(1'b1, 1'b0, 1'b0, 1'b1, mk_pkt(32'h30 + 32'(4*k), 32'h34 + 32'(4*k), 5'd2, 32'h9));
      #1;
      chk($sformatf("wrap_pp_commit%0d", k), 64'(commit),        64'd1);
      chk($sformatf("wrap_pp_pc%0d", k),     64'(head.pc_rdata), 64'(32'h20 + 32'(4*k)));
      tick();
      chk($sformatf("wrap_pp_count%0d", k), 64'(count),    64'd4);
      chk($sformatf("wrap_pp_ovf%0d", k),   64'(overflow), 64'd0);
    end
    set_in(1'b0, 1'b0, 1'b0, 1'b1, '0);
    for (int k = 0; k < 4; k++) begin
      #1;
      chk($sformatf("wrap_drain_pc%0d", k), 64'(head.pc_rdata), 64'(32'h28 + 32'(4*k)));
      tick();
    end
    #1;
    chk("wrap_empty", 64'(out_valid), 64'd0);

    // Flush with three queued and out_ready high: one commit, then empty
    do_reset();
    push_n(3, 32'h50);
    set_in(1'b1, 1'b0, 1'b1, 1'b1, mk_pkt(32'h99, 32'h9D, 5'd4, 32'h4));
    #1;
    chk("flush_commit", 64'(commit), 64'd1);
    tick();
    set_in(1'b0, 1'b0, 1'b0, 1'b0, '0);
    #1;
    chk("flush_count", 64'(count),     64'd0);
    chk("flush_valid", 64'(out_valid), 64'd0);
    chk("flush_order", order,          64'd1);
    push_n(1, 32'h70);
    #1;
    chk("flush_after_pc",    64'(head.pc_rdata), 64'h70);
    chk("flush_after_count", 64'(count),         64'd1);
    tick();

    // Halt detection
    do_reset();
    set_in(1'b1, 1'b0, 1'b0, 1'b1, mk_pkt(32'h80, 32'h80, 5'd1, 32'h1));
    tick();
    set_in(1'b0, 1'b0, 1'b0, 1'b1, '0);
    #1;
    chk("halt_commit", 64'(commit), 64'd1);
    chk("halt_before", 64'(halt),   64'd0);
    tick();
`ifdef RVFI_HALT_DETECT_EN
    chk("halt_set", 64'(halt), 64'd1);
`else
    chk("halt_tied", 64'(halt), 64'd0);
`endif
    set_in(1'b1, 1'b0, 1'b0, 1'b1, mk_pkt(32'h90, 32'h94, 5'd1, 32'h2));
    tick();
    set_in(1'b0, 1'b0, 1'b0, 1'b1, '0);
    tick();
    chk("halt_order", order, 64'd2);
`ifdef RVFI_HALT_DETECT_EN
    chk("halt_sticky", 64'(halt), 64'd1);
`else
    chk("halt_tied2", 64'(halt), 64'd0);
`endif

    // Randomized run against a queue model
    do_reset();
    mq.delete();
    m_order = '0;
    m_ovf   = 1'b0;
    m_halt  = 1'b0;
    for (int i = 0; i < 600; i++) begin
      rp = rand_pkt();
      set_in($urandom_range(0, 3) != 0, $urandom_range(0, 3) == 0,
             $urandom_range(0, 19) == 0,
             ((i / 50) % 2 == 0) ? ($urandom_range(0, 3) == 0) : ($urandom_range(0, 3) != 0),
             rp);
      #1;
      chk("rnd_valid",    64'(out_valid), 64'(mq.size() != 0));
      chk("rnd_count",    64'(count),     64'(mq.size()));
      chk("rnd_commit",   64'(commit),    64'((mq.size() != 0) && out_ready));
      chk("rnd_order",    order,          m_order);
      chk("rnd_overflow", 64'(overflow),  64'(m_ovf));
      chk("rnd_halt",     64'(halt),      64'(m_halt));
      if (mq.size() != 0) chk_pkt("rnd_pkt", head, scrubbed(mq[0]));

      m_pop  = (mq.size() != 0) && out_ready;
      m_push = cap_valid && !cap_stall && !cap_flush;
      m_full = (mq.size() == DEPTH);
      if (m_pop) begin
        m_order = m_order + 64'd1;
`ifdef RVFI_HALT_DETECT_EN
        if (mq[0].pc_wdata == mq[0].pc_rdata) m_halt = 1'b1;
`endif
      end
      if (cap_flush) begin
        mq.delete();
      end else begin
        if (m_pop) void'(mq.pop_front());
        if (m_push) begin
          if (m_full && !m_pop) m_ovf = 1'b1;
          else mq.push_back(rp);
        end
      end
      tick();
    end

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
